// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter onto a single-ported memory with a shared
// bidirectional data bus; one transfer in flight, registered outputs throughout.
module mem_bus_arbiter #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  rdata0,
  output logic [7:0]  rdata1,
  output logic [15:0] mem_addr,
  inout  wire  [7:0]  mem_data,
  output logic        mem_we,
  output logic        mem_cs,
  output logic        busy
);

  localparam logic [3:0] LAT_INIT = 4'(READ_LAT);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t      state_reg;
  logic        last_grant_reg;
  logic        grant_reg;
  logic        we_reg;
  logic        drive_reg;
  logic [7:0]  wdata_reg;
  logic [3:0]  cnt_reg;

  logic        grant_next;
  logic        sel_we;
  logic [15:0] sel_addr;
  logic [7:0]  sel_wdata;

  // On a tie the port that did not win last time gets the bus.
  always_comb begin
    grant_next = (req0 && req1) ? ~last_grant_reg : req1;
    sel_we     = grant_next ? we1 : we0;
    sel_addr   = grant_next ? addr1 : addr0;
    sel_wdata  = grant_next ? wdata1 : wdata0;
  end

  assign mem_data = drive_reg ? wdata_reg : 8'hzz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      grant_reg      <= 1'b0;
      we_reg         <= 1'b0;
      drive_reg      <= 1'b0;
      wdata_reg      <= 8'h00;
      cnt_reg        <= 4'd0;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      rdata0         <= 8'h00;
      rdata1         <= 8'h00;
      mem_addr       <= 16'h0000;
      mem_we         <= 1'b0;
      mem_cs         <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req0 || req1) begin
            // Everything the transfer needs is captured here, so later
            // requester activity cannot disturb it.
            grant_reg      <= grant_next;
            last_grant_reg <= grant_next;
            we_reg         <= sel_we;
            wdata_reg      <= sel_wdata;
            drive_reg      <= sel_we;
            mem_cs         <= 1'b1;
            mem_we         <= sel_we;
            mem_addr       <= sel_addr;
            busy           <= 1'b1;
            state_reg      <= ACCESS;
          end
        end
        ACCESS: begin
          mem_cs    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= 16'h0000;
          drive_reg <= 1'b0;
          if (we_reg) begin
            ack0      <= ~grant_reg;
            ack1      <= grant_reg;
            state_reg <= DONE;
          end else begin
            cnt_reg   <= LAT_INIT;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg <= 4'd1) begin
            if (grant_reg) rdata1 <= mem_data;
            else           rdata0 <= mem_data;
            ack0      <= ~grant_reg;
            ack1      <= grant_reg;
            state_reg <= DONE;
          end
        end
        DONE: begin
          ack0      <= 1'b0;
          ack1      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: vector table plus hand-written corner
// sequences, acks checked against a queue of expected completions.
module tb_mem_bus_arbiter;

  typedef struct {
    bit          port;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rval;
  } vec_t;

  typedef struct {
    bit         port;
    bit         chk_rd;
    logic [7:0] rd;
    int         cyc;
  } exp_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [15:0] addr0 = 0, addr1 = 0;
  logic [7:0]  wdata0 = 0, wdata1 = 0;
  logic        ack0, ack1, mem_we, mem_cs, busy;
  logic [7:0]  rdata0, rdata1;
  logic [15:0] mem_addr;
  wire  [7:0]  mem_data;

  logic        req0_b = 0, req1_b = 0;
  logic        ack0_b, ack1_b, mem_we_b, mem_cs_b, busy_b;
  logic [7:0]  rdata0_b, rdata1_b;
  logic [15:0] mem_addr_b;
  wire  [7:0]  mem_data_b;

  int          total = 0, bad = 0, cyc = 0;
  exp_t        sb[$];
  vec_t        vecs[7];
  logic [7:0]  exp_rd0 = 0, exp_rd1 = 0, mem_rval = 0;
  logic [3:0]  mcnt = 0, mcnt_b = 0;
  logic [15:0] mlast = 0;

  mem_bus_arbiter #(.READ_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_cs(mem_cs), .busy(busy)
  );

  mem_bus_arbiter #(.READ_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req0(req0_b), .req1(req1_b), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0_b), .ack1(ack1_b), .rdata0(rdata0_b), .rdata1(rdata1_b),
    .mem_addr(mem_addr_b), .mem_data(mem_data_b), .mem_we(mem_we_b), .mem_cs(mem_cs_b), .busy(busy_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: read data appears READ_LAT cycles after the chip-select cycle.
  always @(posedge clk) begin
    if (mem_cs && !mem_we) begin
      mcnt  <= 4'd1;
      mlast <= mem_addr;
    end else if (mcnt != 0) mcnt <= mcnt - 4'd1;
    if (mem_cs_b && !mem_we_b) mcnt_b <= 4'd3;
    else if (mcnt_b != 0) mcnt_b <= mcnt_b - 4'd1;
  end
  assign mem_data   = (mcnt == 4'd1)   ? mem_rval : 8'hzz;
  assign mem_data_b = (mcnt_b == 4'd1) ? mem_rval : 8'hzz;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Scoreboard side: every ack must match the oldest expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (ack0 || ack1)) begin
      chk("one_ack", 32'(ack0 & ack1), 0);
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_ack: got=ack%0d want=none", ack1);
      end else begin
        e = sb.pop_front();
        chk("ack_port", 32'(ack1), 32'(e.port));
        chk("ack_cycle", cyc, e.cyc);
        if (e.chk_rd) chk("ack_rdata", 32'(e.port ? rdata1 : rdata0), 32'(e.rd));
        $display("ack port=%0d cyc=%0d rdata0=%h rdata1=%h", ack1, cyc, rdata0, rdata1);
      end
    end
  end

  task automatic wait_ack(input bit p, input int budget);
    bit got;
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      got = p ? ack1 : ack0;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL ack_timeout: port=%0d got=none want=ack", p);
      sb.delete();
    end
  endtask

  task automatic check_reset();
    chk("rst_ctl", 32'({ack0, ack1, mem_cs, mem_we, busy}), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_rdata", 32'({rdata0, rdata1}), 0);
  endtask

  // Called on a falling edge; releases reset on the following falling edge.
  task automatic do_reset();
    rst_n = 0;
    #1 check_reset();
    @(negedge clk);
    check_reset();
    sb.delete();
    exp_rd0 = 0;
    exp_rd1 = 0;
    rst_n = 1;
  endtask

  // Called on a falling edge in an IDLE cycle; returns in the next IDLE cycle.
  task automatic run_xfer(input vec_t v);
    exp_t e;
    chk("idle_busy", 32'(busy), 0);
    mem_rval = v.rval;
    if (v.port) begin req1 = 1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; end
    else        begin req0 = 1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; end
    e.port = v.port; e.chk_rd = !v.we; e.rd = v.rval; e.cyc = cyc + (v.we ? 2 : 3);
    sb.push_back(e);
    @(negedge clk);
    chk("acc_cs", 32'(mem_cs), 1);
    chk("acc_we", 32'(mem_we), 32'(v.we));
    chk("acc_addr", 32'(mem_addr), 32'(v.addr));
    if (v.we) chk("acc_wdata", 32'(mem_data), 32'(v.wdata));
    wait_ack(v.port, 8);
    chk("done_bus", 32'({mem_cs, mem_we, mem_addr}), 0);
    req0 = 0; req1 = 0;
    if (!v.we) begin
      if (v.port) exp_rd1 = v.rval;
      else        exp_rd0 = v.rval;
    end
    @(negedge clk);
    chk("rd0_hold", 32'(rdata0), 32'(exp_rd0));
    chk("rd1_hold", 32'(rdata1), 32'(exp_rd1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   r, c, cs_cnt, ack_cyc;
    logic [7:0] rd;
    vecs[0] = '{1'b1, 1'b1, 16'h1234, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 16'h0010, 8'h00, 8'h3C};
    vecs[2] = '{1'b1, 1'b0, 16'h4000, 8'h00, 8'hC3};
    vecs[3] = '{1'b0, 1'b1, 16'hFFFF, 8'h00, 8'h00};
    vecs[4] = '{1'b1, 1'b1, 16'h0000, 8'hFF, 8'h00};
    vecs[5] = '{1'b0, 1'b0, 16'h8001, 8'h00, 8'h00};
    vecs[6] = '{1'b1, 1'b0, 16'h0F0F, 8'h00, 8'h81};

    @(negedge clk);
    do_reset();
    foreach (vecs[i]) run_xfer(vecs[i]);

    // Committed transfer: request dropped and address changed right after grant.
    mem_rval = 8'h3C; req0 = 1; we0 = 0; addr0 = 16'h0010;
    e = '{1'b0, 1'b1, 8'h3C, cyc + 3};
    sb.push_back(e);
    @(posedge clk);
    #1 req0 = 0; addr0 = 16'hFFFF; we0 = 1;
    @(negedge clk);
    chk("commit_acc", 32'({mem_cs, mem_we, mem_addr}), 32'({2'b10, 16'h0010}));
    @(negedge clk);
    chk("wait_bus", 32'({mem_cs, mem_we, mem_addr}), 0);
    chk("wait_busy", 32'(busy), 1);
    wait_ack(1'b0, 6);
    exp_rd0 = 8'h3C;
    chk("commit_mem_addr", 32'(mlast), 32'(16'h0010));
    @(negedge clk);
    @(negedge clk);
    chk("commit_no_rereq", 32'(busy), 0);

    // Both ports held from reset: grants alternate 0,1,0,1.
    req0 = 1; we0 = 1; addr0 = 16'h0100; wdata0 = 8'h11;
    req1 = 1; we1 = 1; addr1 = 16'h0200; wdata1 = 8'h22;
    do_reset();
    r = cyc;
    for (int k = 0; k < 4; k++) begin
      e = '{bit'(k % 2), 1'b0, 8'h00, r + 2 + 3 * k};
      sb.push_back(e);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_addr", 32'(mem_addr), (k % 2) ? 32'h0200 : 32'h0100);
      chk("rr_data", 32'(mem_data), (k % 2) ? 32'h22 : 32'h11);
      @(negedge clk);
      if (k == 3) begin req0 = 0; req1 = 0; end
      else @(negedge clk);
    end
    @(negedge clk);
    chk("rr_stop", 32'(busy), 0);

    // Reset during WAIT abandons the read; a held request is re-granted.
    run_xfer('{1'b1, 1'b0, 16'h0ABC, 8'h00, 8'h5E});
    mem_rval = 8'h66; req1 = 1; we1 = 0; addr1 = 16'h0ABC;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    do_reset();
    r = cyc;
    e = '{1'b1, 1'b1, 8'h66, r + 3};
    sb.push_back(e);
    @(negedge clk);
    chk("regrant_acc", 32'({mem_cs, mem_addr}), 32'({1'b1, 16'h0ABC}));
    wait_ack(1'b1, 6);
    req1 = 0;
    exp_rd1 = 8'h66;
    @(negedge clk);
    chk("rd1_after", 32'(rdata1), 32'(exp_rd1));

    // READ_LAT=3 instance: ack at N+5, chip select for a single cycle.
    c = cyc; cs_cnt = 0; ack_cyc = -1; rd = 8'h00;
    mem_rval = 8'h77; req0_b = 1; we0 = 0; addr0 = 16'h0200;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_cs_b) begin
        cs_cnt++;
        chk("lat3_addr", 32'(mem_addr_b), 32'h0200);
      end
      if (ack0_b && ack_cyc < 0) begin
        ack_cyc = cyc; rd = rdata0_b; req0_b = 0;
        $display("ack3 port=0 cyc=%0d rdata0=%h", cyc, rd);
      end
    end
    chk("lat3_ack_cyc", ack_cyc, c + 5);
    chk("lat3_cs_cnt", cs_cnt, 1);
    chk("lat3_rdata", 32'(rd), 32'h77);
    chk("lat3_idle", 32'({ack1_b, rdata1_b, mem_we_b, busy_b}), 0);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
